reservation_station: RTL
========================

Name: reservation_station

Overview:
- Issue-side partner of the execution unit. Holds decoded instructions until both source operands are available, then dispatches them to the unit.
- Captures operand values and ROB tags at issue time.
- Snoops the common data bus (CDB) to wake up operands that are waiting on a tag.
- Presents one ready entry per cycle to the execution unit over a valid/ready handshake.
- Sits between the issue stage and the add/sub and mul/div execution path of the Tomasulo core.

Parameters:
- DEPTH, 4, number of entries (power of two, 2..8).
- DW, 8, operand/result data width.
- TW, 3, ROB tag width (matches rob_ind).
- FW, 4, func code width.
- RW, 4, destination register index width.

Ports:
- clk1 in 1 system clock
- rst in 1 synchronous active-high reset
- flush in 1 clear all entries (mispredict/exception)
- iss_valid in 1 issue request
- iss_ready out 1 free entry available
- iss_func in FW operation code
- iss_rd in RW destination register
- iss_rob in TW ROB index of this instruction
- iss_rs1_rdy in 1 rs1 value valid
- iss_rs1_val in DW rs1 value
- iss_rs1_tag in TW producing ROB tag for rs1
- iss_rs2_rdy in 1 rs2 value valid
- iss_rs2_val in DW rs2 value
- iss_rs2_tag in TW producing ROB tag for rs2
- cdb_valid in 1 CDB broadcast valid
- cdb_tag in TW broadcast ROB tag
- cdb_data in DW broadcast result
- ex_valid out 1 dispatch valid
- ex_ready in 1 execution unit accepts
- rs1_data out DW dispatched rs1 operand
- rs2_data out DW dispatched rs2 operand
- func out FW dispatched op
- rob_ind out TW dispatched ROB index
- rd out RW dispatched destination
- occupancy out $clog2(DEPTH)+1 count of valid entries

Behaviour:
- Reset, or flush at a clock edge: all entry valid bits clear and occupancy becomes 0. iss_ready is then 1 and ex_valid is 0. Dispatch data outputs are 0. Flush wins over issue, CDB and dispatch in the same cycle.
- Per-entry state: busy, func, rd, rob, and for each operand (rdy, val, tag).
- Issue:
  - iss_ready = (occupancy < DEPTH), computed from registered state only.
  - A slot freed by a dispatch in the same cycle does not raise iss_ready.
  - When iss_valid && iss_ready, the lowest-index free entry is written at the edge.
  - iss_valid with iss_ready=0 is ignored. Issue must hold until accepted.
- Issue/CDB bypass: if cdb_valid and cdb_tag equals a not-ready issuing operand's tag in the same cycle, the entry is written with rdy=1 and val=cdb_data.
- Wakeup: on cdb_valid, every busy entry whose operand has rdy=0 and tag==cdb_tag latches cdb_data and sets rdy=1. Both operands of one entry may wake on the same broadcast.
- Dispatch selection:
  - An entry is eligible when busy && rs1.rdy && rs2.rdy, using registered state.
  - A wakeup takes effect the cycle after the broadcast; there is no CDB-to-dispatch bypass.
  - The eligible entry with the oldest issue age wins. Age is tracked by a per-entry age counter or issue-order matrix.
  - ex_valid and the data outputs are combinational from the selected entry.
  - Data outputs are 0 when ex_valid=0.
- Handshake:
  - Once asserted, ex_valid and the payload stay stable until ex_ready. A newer-but-older-aged entry may not preempt a presented entry.
  - The selected entry is freed at the edge where ex_valid && ex_ready.
- Latency: an instruction issued with both operands ready is offered on ex_valid in the next cycle. An instruction waiting on a CDB tag is offered one cycle after that broadcast.
- Occupancy: next = occupancy + issue_accept − dispatch_accept. Simultaneous issue and dispatch leaves it unchanged and never exceeds DEPTH.
- Full with simultaneous dispatch: iss_ready stays 0 that cycle and rises the next cycle.
- A CDB tag that matches no waiting operand has no effect.
- Reset in the middle of a wait discards all entries; no dispatch follows.

Decomposition:
- Shared package tomasulo_pkg holds:
  - width constants DW, TW, FW, RW;
  - func encodings FUNC_ADD=0, FUNC_SUB=1, FUNC_MUL=2, FUNC_DIV=3, FUNC_LD=4, FUNC_ST=5;
  - the operand struct {rdy, val, tag}.
- One natural sub-module, rs_select: a combinational oldest-eligible picker over DEPTH entries, returning a one-hot grant and an any-valid flag.

Test Plan:
- Issue ADD (rs1 = 5 rdy, rs2 = 7 rdy, rob = 2, rd = 3) -> next cycle ex_valid=1, rs1_data=5, rs2_data=7, func=0, rob_ind=2, rd=3. With ex_ready=1, occupancy returns to 0.
- Issue MUL with rs2 waiting on tag 4; later cdb_valid, tag=4, data=0x1A -> ex_valid rises exactly one cycle after the broadcast with rs2_data=0x1A.
- Issue with rs1 tag 6 in the same cycle as a CDB broadcast of tag 6, data 9 -> the entry captures 9. Dispatch occurs next cycle without a further broadcast.
- Fill 4 entries with unready operands -> iss_ready=0 and a 5th issue is ignored. Broadcast the tag of entry 2 and hold ex_ready=1 -> entry 2 dispatches and iss_ready returns the following cycle.
- Two entries become ready in the same cycle, issued in order A then B, with ex_ready=0 for 3 cycles -> A is held stable for 3 cycles, then A dispatches, then B.
- Assert flush while 3 entries are busy and ex_valid=1 -> next cycle occupancy=0, ex_valid=0, iss_ready=1. Assert rst mid-wait -> same result.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core types: datapath widths, func encodings and the operand record.
// Also holds the CDB snoop helper used by both issue bypass and wakeup.
package tomasulo_pkg;

    localparam int DW = 8;
    localparam int TW = 3;
    localparam int FW = 4;
    localparam int RW = 4;

    typedef enum logic [FW-1:0] {
        FUNC_ADD = 4'd0,
        FUNC_SUB = 4'd1,
        FUNC_MUL = 4'd2,
        FUNC_DIV = 4'd3,
        FUNC_LD  = 4'd4,
        FUNC_ST  = 4'd5
    } func_e;

    typedef struct packed {
        logic          rdy;
        logic [DW-1:0] val;
        logic [TW-1:0] tag;
    } opnd_t;

    typedef struct packed {
        logic          busy;
        logic [FW-1:0] func;
        logic [RW-1:0] rd;
        logic [TW-1:0] rob;
        opnd_t         rs1;
        opnd_t         rs2;
    } entry_t;

    // A waiting operand whose producer tag is on the CDB takes the broadcast value.
    function automatic opnd_t snoop(input opnd_t op, input logic cdb_vld,
                                    input logic [TW-1:0] cdb_tag, input logic [DW-1:0] cdb_dat);
        opnd_t r;
        r = op;
        if (!op.rdy && cdb_vld && (op.tag == cdb_tag)) begin
            r.rdy = 1'b1;
            r.val = cdb_dat;
        end
        return r;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Issue, CDB and dispatch bundle of the reservation station; master drives issue/CDB/ex_ready.
// slave is the station itself: it returns iss_ready and the dispatch valid/payload.
interface reservation_station_if #(
    parameter int DEPTH = 4
);
    import tomasulo_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic          iss_valid;
    logic          iss_ready;
    logic [FW-1:0] iss_func;
    logic [RW-1:0] iss_rd;
    logic [TW-1:0] iss_rob;
    logic          iss_rs1_rdy;
    logic [DW-1:0] iss_rs1_val;
    logic [TW-1:0] iss_rs1_tag;
    logic          iss_rs2_rdy;
    logic [DW-1:0] iss_rs2_val;
    logic [TW-1:0] iss_rs2_tag;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic          ex_valid;
    logic          ex_ready;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic [FW-1:0] func;
    logic [TW-1:0] rob_ind;
    logic [RW-1:0] rd;
    logic [CW-1:0] occupancy;

    modport master (
        output iss_valid, iss_func, iss_rd, iss_rob,
               iss_rs1_rdy, iss_rs1_val, iss_rs1_tag,
               iss_rs2_rdy, iss_rs2_val, iss_rs2_tag,
               cdb_valid, cdb_tag, cdb_data, ex_ready,
        input  iss_ready, ex_valid, rs1_data, rs2_data, func, rob_ind, rd, occupancy
    );

    modport slave (
        input  iss_valid, iss_func, iss_rd, iss_rob,
               iss_rs1_rdy, iss_rs1_val, iss_rs1_tag,
               iss_rs2_rdy, iss_rs2_val, iss_rs2_tag,
               cdb_valid, cdb_tag, cdb_data, ex_ready,
        output iss_ready, ex_valid, rs1_data, rs2_data, func, rob_ind, rd, occupancy
    );

endinterface

// File: rtl/rs_select.sv
// Oldest-eligible picker: one-hot grant of the eligible entry no other eligible entry predates.
// Purely combinational; i_older[j][i] set means entry j was issued before entry i.
module rs_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]            i_elig,
    input  logic [DEPTH-1:0][DEPTH-1:0] i_older,
    output logic [DEPTH-1:0]            o_gnt,
    output logic                        o_any
);

    logic [DEPTH-1:0] w_blk;

    always_comb begin
        w_blk = '0;
        o_gnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                w_blk[i] = w_blk[i] | (i_elig[j] & i_older[j][i]);
            end
            o_gnt[i] = i_elig[i] & ~w_blk[i];
        end
    end

    assign o_any = |i_elig;

endmodule

// File: rtl/reservation_station.sv
// Holds issued ops until both operands are known, wakes them from the CDB, dispatches oldest-ready.
// Dispatch one cycle after operands complete; a presented op is held stable until ex_ready.
module reservation_station
    import tomasulo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk1,
    input  logic                 rst,
    input  logic                 flush,
    reservation_station_if.slave rs_if
);

    localparam int CW = $clog2(DEPTH) + 1;

    entry_t                      r_ent [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] r_older;
    logic [CW-1:0]               r_occ;
    logic                        r_hold;
    logic [DEPTH-1:0]            r_hold_gnt;

    logic [DEPTH-1:0] w_elig;
    logic [DEPTH-1:0] w_pick_gnt;
    logic [DEPTH-1:0] w_gnt;
    logic [DEPTH-1:0] w_free_gnt;
    logic             w_found;
    logic             w_any;
    logic             w_ex_valid;
    logic             w_iss_acc;
    logic             w_disp_acc;
    opnd_t            w_iss_rs1;
    opnd_t            w_iss_rs2;
    entry_t           w_new;
    logic [DW-1:0]    w_rs1;
    logic [DW-1:0]    w_rs2;
    logic [FW-1:0]    w_func;
    logic [TW-1:0]    w_rob;
    logic [RW-1:0]    w_rd;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_elig[i] = r_ent[i].busy & r_ent[i].rs1.rdy & r_ent[i].rs2.rdy;
        end
    end

    rs_select #(.DEPTH(DEPTH)) u_select (
        .i_elig  (w_elig),
        .i_older (r_older),
        .o_gnt   (w_pick_gnt),
        .o_any   (w_any)
    );

    // A presented-but-unaccepted entry keeps the grant even if an older one wakes up.
    assign w_gnt      = r_hold ? r_hold_gnt : w_pick_gnt;
    assign w_ex_valid = r_hold | w_any;
    assign w_iss_acc  = rs_if.iss_valid & rs_if.iss_ready;
    assign w_disp_acc = w_ex_valid & rs_if.ex_ready;

    always_comb begin
        w_free_gnt = '0;
        w_found    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r_ent[i].busy && !w_found) begin
                w_free_gnt[i] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

    assign w_iss_rs1 = {rs_if.iss_rs1_rdy, rs_if.iss_rs1_val, rs_if.iss_rs1_tag};
    assign w_iss_rs2 = {rs_if.iss_rs2_rdy, rs_if.iss_rs2_val, rs_if.iss_rs2_tag};

    always_comb begin
        w_new      = '0;
        w_new.busy = 1'b1;
        w_new.func = rs_if.iss_func;
        w_new.rd   = rs_if.iss_rd;
        w_new.rob  = rs_if.iss_rob;
        w_new.rs1  = snoop(w_iss_rs1, rs_if.cdb_valid, rs_if.cdb_tag, rs_if.cdb_data);
        w_new.rs2  = snoop(w_iss_rs2, rs_if.cdb_valid, rs_if.cdb_tag, rs_if.cdb_data);
    end

    always_comb begin
        w_rs1  = '0;
        w_rs2  = '0;
        w_func = '0;
        w_rob  = '0;
        w_rd   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rs1  = w_rs1  | ({DW{w_gnt[i]}} & r_ent[i].rs1.val);
            w_rs2  = w_rs2  | ({DW{w_gnt[i]}} & r_ent[i].rs2.val);
            w_func = w_func | ({FW{w_gnt[i]}} & r_ent[i].func);
            w_rob  = w_rob  | ({TW{w_gnt[i]}} & r_ent[i].rob);
            w_rd   = w_rd   | ({RW{w_gnt[i]}} & r_ent[i].rd);
        end
    end

    always_ff @(posedge clk1) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
            r_older    <= '0;
            r_occ      <= '0;
            r_hold     <= 1'b0;
            r_hold_gnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_ent[i].busy) begin
                    r_ent[i].rs1 <= snoop(r_ent[i].rs1, rs_if.cdb_valid, rs_if.cdb_tag, rs_if.cdb_data);
                    r_ent[i].rs2 <= snoop(r_ent[i].rs2, rs_if.cdb_valid, rs_if.cdb_tag, rs_if.cdb_data);
                end
                if (w_disp_acc && w_gnt[i]) begin
                    r_ent[i].busy <= 1'b0;
                end
                // New entry is younger than everything; the row clear also keeps the diagonal 0.
                if (w_iss_acc && w_free_gnt[i]) begin
                    r_ent[i] <= w_new;
                    for (int j = 0; j < DEPTH; j++) begin
                        r_older[j][i] <= 1'b1;
                    end
                    for (int j = 0; j < DEPTH; j++) begin
                        r_older[i][j] <= 1'b0;
                    end
                end
            end
            r_occ      <= r_occ + CW'(w_iss_acc) - CW'(w_disp_acc);
            r_hold     <= w_ex_valid & ~rs_if.ex_ready;
            r_hold_gnt <= w_gnt;
        end
    end

    assign rs_if.iss_ready = (r_occ < CW'(DEPTH));
    assign rs_if.ex_valid  = w_ex_valid;
    assign rs_if.rs1_data  = w_rs1;
    assign rs_if.rs2_data  = w_rs2;
    assign rs_if.func      = w_func;
    assign rs_if.rob_ind   = w_rob;
    assign rs_if.rd        = w_rd;
    assign rs_if.occupancy = r_occ;

endmodule
